// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage data access engine: posted store buffer, handshaked
//            load FSM, byte/half extraction, address-error detection, stall.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W   = 32,
  parameter int SB_DEPTH = 4,
  parameter bit SWAP     = 1'b1
) (
  input  logic                      cpu_clk_50M,
  input  logic                      cpu_rst_n,
  input  logic                      req_valid,
  input  logic [2:0]                req_op,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [31:0]               req_wdata,
  input  logic                      flush,
  output logic                      req_ready,
  output logic                      stall_o,
  output logic                      rdata_valid,
  output logic [31:0]               rdata,
  output logic                      exc_o,
  output logic [4:0]                exc_code,
  output logic [ADDR_W-1:0]         badvaddr,
  output logic                      bus_req,
  output logic [3:0]                bus_we,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [31:0]               bus_wdata,
  input  logic                      bus_gnt,
  input  logic                      bus_rvalid,
  input  logic [31:0]               bus_rdata,
  output logic [$clog2(SB_DEPTH):0] sb_count
);

  localparam int c_PTR_W = $clog2(SB_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_SB_FULL = c_CNT_W'(SB_DEPTH);

  localparam logic [2:0] c_OP_LB  = 3'b000;
  localparam logic [2:0] c_OP_LBU = 3'b001;
  localparam logic [2:0] c_OP_LH  = 3'b010;
  localparam logic [2:0] c_OP_LHU = 3'b011;
  localparam logic [2:0] c_OP_LW  = 3'b100;
  localparam logic [2:0] c_OP_SB  = 3'b101;
  localparam logic [2:0] c_OP_SH  = 3'b110;
  localparam logic [2:0] c_OP_SW  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LREQ  = 3'd1,
    S_LWAIT = 3'd2,
    S_LDROP = 3'd3,
    S_LDONE = 3'd4
  } state_t;

  function automatic logic [31:0] f_bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  state_t              r_state;
  logic [2:0]          r_ld_op;
  logic [ADDR_W-1:0]   r_ld_addr;
  logic [31:0]         r_word;
  logic                r_exc;
  logic [4:0]          r_exc_code;
  logic [ADDR_W-1:0]   r_badvaddr;

  logic [ADDR_W-1:0]   r_sb_addr  [SB_DEPTH];
  logic [3:0]          r_sb_lanes [SB_DEPTH];
  logic [31:0]         r_sb_data  [SB_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_sb_count;

  logic                w_is_store;
  logic                w_misalign;
  logic [3:0]          w_lanes;
  logic [31:0]         w_store_data;
  logic                w_idle;
  logic                w_sb_full;
  logic                w_sb_empty;
  logic                w_req_misalign;
  logic                w_push;
  logic                w_drain;
  logic                w_pop;
  logic                w_load_start;
  logic                w_ldone;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_rdata;

  // Request decode: store/load class, alignment, byte lanes and replicated store data
  always_comb begin
    w_is_store   = req_op[2] & (req_op[1] | req_op[0]);
    w_misalign   = 1'b0;
    w_lanes      = 4'b1111;
    w_store_data = req_wdata;
    case (req_op)
      c_OP_LB, c_OP_LBU, c_OP_SB: begin
        w_lanes      = 4'b1000 >> req_addr[1:0];
        w_store_data = {4{req_wdata[7:0]}};
      end
      c_OP_LH, c_OP_LHU, c_OP_SH: begin
        w_misalign   = req_addr[0];
        w_lanes      = req_addr[1] ? 4'b0011 : 4'b1100;
        w_store_data = {2{req_wdata[15:0]}};
      end
      default: begin
        w_misalign   = |req_addr[1:0];
      end
    endcase
  end

  assign w_idle         = (r_state == S_IDLE);
  assign w_sb_full      = (r_sb_count == c_SB_FULL);
  assign w_sb_empty     = (r_sb_count == '0);
  assign w_req_misalign = w_idle & req_valid & w_misalign;
  // Full flag is the registered one: a same-cycle pop never frees a slot early
  assign w_push         = w_idle & req_valid & w_is_store & ~w_misalign & ~w_sb_full & ~flush;
  // Buffered stores own the bus whenever the load FSM is idle
  assign w_drain        = w_idle & ~w_sb_empty;
  assign w_pop          = w_drain & bus_gnt;
  assign w_load_start   = w_idle & req_valid & ~w_is_store & ~w_misalign & w_sb_empty & ~flush;
  assign w_ldone        = (r_state == S_LDONE) & ~flush;

  // Request inputs are gated by reset so the handshake reads 0 while held in reset
  assign req_ready   = cpu_rst_n & (w_req_misalign | w_push | w_ldone);
  assign stall_o     = cpu_rst_n & req_valid & ~req_ready & ~flush;
  assign rdata_valid = w_ldone;
  assign rdata       = w_rdata;
  assign exc_o       = r_exc;
  assign exc_code    = r_exc_code;
  assign badvaddr    = r_badvaddr;
  assign sb_count    = r_sb_count;

  assign bus_req   = w_drain | (r_state == S_LREQ);
  assign bus_we    = w_drain ? r_sb_lanes[r_rd_ptr] : 4'b0000;
  assign bus_addr  = w_drain ? r_sb_addr[r_rd_ptr] :
                     (r_state == S_LREQ) ? {r_ld_addr[ADDR_W-1:2], 2'b00} : '0;
  assign bus_wdata = w_drain ? r_sb_data[r_rd_ptr] : 32'h0;

  // Load FSM plus registered exception reporting
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state    <= S_IDLE;
      r_ld_op    <= 3'b000;
      r_ld_addr  <= '0;
      r_word     <= 32'h0;
      r_exc      <= 1'b0;
      r_exc_code <= 5'h00;
      r_badvaddr <= '0;
    end else begin
      r_exc <= w_req_misalign & ~flush;
      if (w_req_misalign & ~flush) begin
        r_exc_code <= w_is_store ? 5'h05 : 5'h04;
        r_badvaddr <= req_addr;
      end
      case (r_state)
        S_IDLE: begin
          if (w_load_start) begin
            r_state   <= S_LREQ;
            r_ld_op   <= req_op;
            r_ld_addr <= req_addr;
          end
        end
        S_LREQ: begin
          // A granted read must still have its data consumed even if flushed
          if (bus_gnt)    r_state <= flush ? S_LDROP : S_LWAIT;
          else if (flush) r_state <= S_IDLE;
        end
        S_LWAIT: begin
          if (bus_rvalid) begin
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              r_word  <= SWAP ? f_bswap(bus_rdata) : bus_rdata;
              r_state <= S_LDONE;
            end
          end else if (flush) begin
            r_state <= S_LDROP;
          end
        end
        S_LDROP: begin
          if (bus_rvalid) r_state <= S_IDLE;
        end
        S_LDONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Store-buffer pointers and occupancy; pointers wrap naturally at SB_DEPTH
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sb_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_sb_count <= r_sb_count + c_CNT_W'(1);
        2'b01:   r_sb_count <= r_sb_count - c_CNT_W'(1);
        default: r_sb_count <= r_sb_count;
      endcase
    end
  end

  // Store-buffer payload storage; entries already hold bus-ready address/lanes/data
  always_ff @(posedge cpu_clk_50M) begin
    if (w_push) begin
      r_sb_addr[r_wr_ptr]  <= {req_addr[ADDR_W-1:2], 2'b00};
      r_sb_lanes[r_wr_ptr] <= w_lanes;
      r_sb_data[r_wr_ptr]  <= SWAP ? f_bswap(w_store_data) : w_store_data;
    end
  end

  // Load result extraction from the captured core-order word
  always_comb begin
    w_byte = r_word[31:24];
    case (r_ld_addr[1:0])
      2'b01:   w_byte = r_word[23:16];
      2'b10:   w_byte = r_word[15:8];
      2'b11:   w_byte = r_word[7:0];
      default: w_byte = r_word[31:24];
    endcase
    w_half = r_ld_addr[1] ? r_word[15:0] : r_word[31:16];
    case (r_ld_op)
      c_OP_LB:  w_rdata = {{24{w_byte[7]}}, w_byte};
      c_OP_LBU: w_rdata = {24'h0, w_byte};
      c_OP_LH:  w_rdata = {{16{w_half[15]}}, w_half};
      c_OP_LHU: w_rdata = {16'h0, w_half};
      default:  w_rdata = r_word;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit (SWAP=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        req_ready;
  logic        stall_o;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        exc_o;
  logic [4:0]  exc_code;
  logic [31:0] badvaddr;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic [2:0]  sb_count;

  // Bus side: either driven by hand or by an auto-responding little-endian RAM
  logic        auto_bus;
  logic        man_gnt;
  logic        man_rvalid;
  logic [31:0] man_rdata;
  logic        rv_pend;
  logic [31:0] rv_data;
  logic [31:0] mem [0:255];

  int          checks = 0;
  int          errors = 0;
  int          nlog;
  logic [3:0]  logv [0:7];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .SB_DEPTH(4), .SWAP(1'b1)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n  (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .flush      (flush),
    .req_ready  (req_ready),
    .stall_o    (stall_o),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .exc_o      (exc_o),
    .exc_code   (exc_code),
    .badvaddr   (badvaddr),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .sb_count   (sb_count)
  );

  assign bus_gnt    = auto_bus ? bus_req : man_gnt;
  assign bus_rvalid = auto_bus ? rv_pend : man_rvalid;
  assign bus_rdata  = auto_bus ? rv_data : man_rdata;

  // RAM model: core lane k (we bit 3-k) lands in bus byte k once byte-swapped
  always @(posedge clk) begin
    rv_pend <= 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus_req && bus_gnt) begin
      if (bus_we == 4'b0000) begin
        rv_pend <= 1'b1;
        rv_data <= mem[bus_addr[9:2]];
      end else begin
        for (int k = 0; k < 4; k++)
          if (bus_we[3-k]) mem[bus_addr[9:2]][8*k +: 8] <= bus_wdata[8*k +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Minimum-latency load with a hand-driven bus: stall in cycles 0-2, result in 3
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] bword, input logic [31:0] exp);
    req_valid = 1'b1; req_op = op; req_addr = addr; man_gnt = 1'b0; man_rvalid = 1'b0;
    #1;
    chk({tag, " c0 stall"}, stall_o, 1);
    cyc(); man_gnt = 1'b1; #1;
    chk({tag, " c1 stall"}, stall_o, 1);
    chk({tag, " c1 req/we"}, {bus_req, bus_we}, 5'b10000);
    chk({tag, " c1 addr"}, bus_addr, {addr[31:2], 2'b00});
    cyc(); man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = bword; #1;
    chk({tag, " c2 stall"}, stall_o, 1);
    cyc(); man_rvalid = 1'b0; #1;
    chk({tag, " c3 ready/valid/stall"}, {req_ready, rdata_valid, stall_o}, 3'b110);
    chk({tag, " c3 rdata"}, rdata, exp);
    cyc(); req_valid = 1'b0;
  endtask

  // Load against the auto RAM, logging every granted bus access's byte enables
  task automatic auto_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] exp);
    bit done;
    done = 1'b0; nlog = 0;
    auto_bus = 1'b1; req_valid = 1'b1; req_op = op; req_addr = addr;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (bus_req && bus_gnt && nlog < 8) begin
        logv[nlog] = bus_we;
        nlog++;
      end
      if (req_ready) done = 1'b1;
      else cyc();
    end
    chk({tag, " completed"}, done, 1);
    chk({tag, " rdata_valid"}, rdata_valid, 1);
    chk({tag, " rdata"}, rdata, exp);
    cyc(); req_valid = 1'b0; auto_bus = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset with random inputs ----
    rst_n = 1'b0; auto_bus = 1'b0; flush = 1'b0;
    req_valid = 1'b1; req_op = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    man_gnt = 1'($urandom_range(0, 1)); man_rvalid = 1'($urandom_range(0, 1)); man_rdata = $urandom;
    repeat (3) cyc();
    req_op = 3'($urandom_range(0, 7)); req_addr = $urandom;
    #1;
    chk("rst bus_req", bus_req, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst rdata_valid", rdata_valid, 0);
    chk("rst rdata", rdata, 0);
    chk("rst exc", {exc_o, exc_code}, 0);
    chk("rst badvaddr", badvaddr, 0);
    chk("rst sb_count", sb_count, 0);

    cyc();
    req_valid = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; flush = 1'b0;
    rst_n = 1'b1;
    cyc();

    // ---- SW 0x12345678 to 0x100, byte-swapped onto the bus ----
    req_valid = 1'b1; req_op = 3'b111; req_addr = 32'h100; req_wdata = 32'h1234_5678;
    #1;
    chk("sw ready", {req_ready, stall_o}, 2'b10);
    cyc(); req_valid = 1'b0; #1;
    chk("sw sb_count", sb_count, 1);
    chk("sw bus_req/we", {bus_req, bus_we}, 5'b11111);
    chk("sw bus_addr", bus_addr, 32'h100);
    chk("sw bus_wdata", bus_wdata, 32'h7856_3412);
    cyc(); #1;
    chk("sw held w/o gnt", {bus_req, bus_wdata}, {1'b1, 32'h7856_3412});
    cyc(); man_gnt = 1'b1; #1;
    cyc(); man_gnt = 1'b0; #1;
    chk("sw popped", {bus_req, sb_count}, 4'b0000);

    // ---- loads, core word 0x80FF7F01 (bus word byte-swapped) ----
    cyc();
    do_load("LB 203",  3'b000, 32'h203, 32'h017F_FF80, 32'h0000_0001);
    do_load("LB 200",  3'b000, 32'h200, 32'h017F_FF80, 32'hFFFF_FF80);
    do_load("LBU 200", 3'b001, 32'h200, 32'h017F_FF80, 32'h0000_0080);
    do_load("LH 200",  3'b010, 32'h200, 32'h017F_FF80, 32'hFFFF_80FF);
    do_load("LHU 202", 3'b011, 32'h202, 32'h017F_FF80, 32'h0000_7F01);
    do_load("LW 200",  3'b100, 32'h200, 32'h017F_FF80, 32'h80FF_7F01);

    // ---- address errors ----
    req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h102;
    #1;
    chk("adel ready/req/stall", {req_ready, bus_req, stall_o}, 3'b100);
    cyc(); req_valid = 1'b0; #1;
    chk("adel exc", {exc_o, exc_code}, {1'b1, 5'h04});
    chk("adel badvaddr", badvaddr, 32'h102);
    cyc(); req_valid = 1'b1; req_op = 3'b110; req_addr = 32'h101; req_wdata = 32'hBEEF; #1;
    chk("ades ready", req_ready, 1);
    cyc(); req_valid = 1'b0; #1;
    chk("ades exc", {exc_o, exc_code}, {1'b1, 5'h05});
    chk("ades badvaddr/sb", {badvaddr, 3'(sb_count)}, {32'h101, 3'd0});
    cyc(); req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h3; flush = 1'b1; #1;
    cyc(); req_valid = 1'b0; flush = 1'b0; #1;
    chk("flushed adel no exc", {exc_o, badvaddr}, {1'b0, 32'h101});

    // ---- store buffer fill to full with gnt low ----
    cyc();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_op = 3'b101; req_addr = 32'h300 + 32'(i);
      req_wdata = 32'h11 * 32'(i + 1);
      #1;
      chk("fill accept", req_ready, 1);
      cyc();
    end
    req_addr = 32'h304; req_wdata = 32'h55; #1;
    chk("full stall", {req_ready, stall_o, sb_count}, {2'b01, 3'd4});
    chk("full head", {bus_we, bus_addr, bus_wdata}, {4'b1000, 32'h300, 32'h1111_1111});
    cyc(); man_gnt = 1'b1; #1;
    chk("pop cycle no accept", req_ready, 0);
    cyc(); man_gnt = 1'b0; #1;
    chk("after pop", {req_ready, sb_count}, {1'b1, 3'd3});
    chk("next head", {bus_we, bus_addr}, {4'b0100, 32'h300});
    cyc(); req_valid = 1'b0; #1;
    chk("refull", sb_count, 4);
    auto_bus = 1'b1;
    for (int n = 0; n < 20 && sb_count != 0; n++) cyc();
    #1;
    chk("drained", sb_count, 0);
    chk("ram 0x300", mem[8'hC0], 32'h4433_2211);
    chk("ram 0x304", mem[8'hC1], 32'h0000_0055);
    auto_bus = 1'b0;

    // ---- load behind two buffered stores ----
    cyc(); req_valid = 1'b1; req_op = 3'b101; req_addr = 32'h310; req_wdata = 32'hA5; #1;
    chk("st1 accept", req_ready, 1);
    cyc(); req_addr = 32'h312; req_wdata = 32'hC3; #1;
    chk("st2 accept", req_ready, 1);
    cyc();
    auto_load("LB 312 behind st", 3'b000, 32'h312, 32'hFFFF_FFC3);
    chk("order n", nlog, 3);
    chk("order 0", logv[0], 4'b1000);
    chk("order 1", logv[1], 4'b0010);
    chk("order 2", logv[2], 4'b0000);
    auto_load("LBU 310", 3'b001, 32'h310, 32'h0000_00A5);

    // ---- flush in LWAIT, late rvalid dropped ----
    req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h400; man_gnt = 1'b0; man_rvalid = 1'b0;
    #1;
    chk("fl c0 stall", stall_o, 1);
    cyc(); man_gnt = 1'b1; #1;
    chk("fl c1 req", bus_req, 1);
    cyc(); man_gnt = 1'b0; flush = 1'b1; #1;
    chk("fl c2", {req_ready, stall_o}, 2'b00);
    cyc(); flush = 1'b0; req_valid = 1'b0; #1;
    chk("fl c3", {bus_req, rdata_valid}, 2'b00);
    cyc(); man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF; #1;
    chk("fl c4 drop", {rdata_valid, req_ready}, 2'b00);
    cyc(); man_rvalid = 1'b0;
    req_valid = 1'b1; req_op = 3'b101; req_addr = 32'h321; req_wdata = 32'h7E; #1;
    chk("idle after drop", req_ready, 1);
    cyc(); req_op = 3'b111; req_addr = 32'h324; flush = 1'b1; #1;
    chk("flushed store", {req_ready, stall_o, sb_count}, {2'b00, 3'd1});
    cyc(); flush = 1'b0; req_valid = 1'b0; #1;
    chk("buffer kept", sb_count, 1);
    cyc();
    auto_load("LW 320", 3'b100, 32'h320, 32'h007E_0000);
    chk("drain then read", {logv[0], logv[1]}, 8'b0100_0000);
    do_load("LW 200 post", 3'b100, 32'h200, 32'h0403_0201, 32'h0102_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
